pc_fetch: RTL and testbench
===========================

Name: pc_fetch

Overview:
- Program-counter stage directly upstream of the 4 KiB instruction memory.
- Holds the architectural fetch PC and drives it to the instruction memory address input.
- Selects the next PC from the following sources: sequential, branch, jump, register jump, exception vector and ERET.
- Honours pipeline stalls, and buffers a redirect that arrives during a stall so that the redirect is not lost.

Parameters:
- RESET_PC, 32'h0000_3000: PC value after reset; the instruction memory window base.
- EXC_VECTOR, 32'h0000_4180: exception entry address.
- IM_BYTES, 4096: size of the instruction window, used for the range check.

Ports:
- clk  in  1  — system clock; all state updates on rising edge.
- rst  in  1  — asynchronous, active-high reset.
- stall_i  in  1  — hazard unit hold; the PC must not advance.
- br_taken_i  in  1  — ID-stage branch resolved taken.
- br_target_i  in  32  — branch target byte address.
- j_i  in  1  — ID-stage J/JAL.
- j_index_i  in  26  — instr_index field of the jump instruction.
- id_pc_plus4_i  in  32  — PC+4 of the instruction in ID; used for the jump region bits.
- jr_i  in  1  — ID-stage JR/JALR.
- jr_target_i  in  32  — forwarded rs value.
- exc_i  in  1  — exception taken (from CP0).
- eret_i  in  1  — ERET executing.
- epc_i  in  32  — return address for ERET.
- pc_o  out  32  — current fetch PC, goes to the instruction memory address input.
- pc_plus4_o  out  32  — pc_o + 4, carried into IF/ID.
- pend_o  out  1  — redirect buffered, waiting for stall release.
- misalign_o  out  1  — pc_o[1:0] != 0.
- range_err_o  out  1  — pc_o outside the instruction window [RESET_PC, RESET_PC+IM_BYTES).
- fetch_cnt_o  out  32  — count of PC advances.

Behaviour:
- Reset:
  - Asynchronous and active-high; takes effect immediately regardless of clk.
  - pc_o = RESET_PC, pend_o = 0, fetch_cnt_o = 0.
  - Asserting rst mid-operation discards any pending redirect.
- Derived outputs:
  - pc_plus4_o, misalign_o and range_err_o are combinational on the registered PC.
  - Range test: (pc_o - RESET_PC) >= IM_BYTES, using unsigned 32-bit subtraction. A PC below the base therefore wraps and flags.
- Redirect decode (combinational), priority jr_i > j_i > br_taken_i:
  - jr_i: target = jr_target_i.
  - j_i: target = {id_pc_plus4_i[31:28], j_index_i, 2'b00}.
  - br_taken_i: target = br_target_i.
  - redir = OR of the three request inputs.
- Next-PC priority, evaluated each rising edge:
  1. exc_i: PC <= EXC_VECTOR; pending cleared. Ignores stall_i.
  2. eret_i, if exc_i is low: PC <= epc_i; pending cleared. Ignores stall_i.
  3. stall_i = 1:
     - PC holds.
     - If redir, pend_target <= decoded target and pend_valid <= 1. A newer redirect overwrites the buffered one.
     - Otherwise the buffer holds its contents.
  4. stall_i = 0 and redir: PC <= decoded target; pend_valid <= 0. The live redirect wins over the buffered one.
  5. stall_i = 0 and pend_valid: PC <= pend_target; pend_valid <= 0.
  6. Otherwise: PC <= PC + 4. Addition is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Latency:
  - A redirect takes effect in pc_o one cycle after it is presented, when not stalled.
  - A buffered redirect appears in pc_o on the first edge with stall_i = 0.
- State: two-state buffer, IDLE (pend_valid = 0) and PEND (pend_valid = 1).
  - IDLE -> PEND on stall & redir & !exc & !eret.
  - PEND -> IDLE on !stall, exc or eret.
  - pend_o = pend_valid.
- fetch_cnt_o:
  - Increments by 1 on every edge where the PC register is loaded (rules 1, 2, 4, 5, 6).
  - Holds under stall; wraps modulo 2^32.
- Misaligned or out-of-range PCs are flagged only; the PC is not corrected. CP0 decides on any exception.

Decomposition:
- Shared package mips_pkg:
  - RESET_PC and EXC_VECTOR defaults.
  - Word width constant (32).
  - Next-PC source encoding: NPC_SEQ, NPC_BR, NPC_J, NPC_JR, NPC_EXC, NPC_ERET, NPC_PEND.
- Sub-module npc_sel (combinational): redirect decode, priority selection, source code output.
- Register state stays in pc_fetch.

Test Plan:
- Reset then 4 free-running clocks: pc_o sequence is 3000, 3004, 3008, 300C, 3010; fetch_cnt_o = 4; range_err_o = 0.
- At pc_o = 3010, br_taken_i = 1 with br_target_i = 3040 for one cycle: next pc_o = 3040, then 3044.
- stall_i high for 3 cycles, with j_i = 1, j_index_i = 0x000C10 and id_pc_plus4_i = 3008 on the first stalled cycle:
  - pc_o frozen and pend_o = 1 while stalled.
  - After release, pc_o = 0000_3040 and pend_o = 0.
  - fetch_cnt_o unchanged during the stall.
- stall_i high with jr_i (target 3100), then exc_i in the next stalled cycle: pc_o = 4180 and pend_o = 0. The buffered 3100 is never fetched.
- Same edge with exc_i = 1, eret_i = 1 and epc_i = 3020: pc_o = 4180. The following cycle, with eret_i only: pc_o = 3020.
- Edge cases:
  - jr_target_i = 3002: misalign_o = 1.
  - jr_target_i = 4000: range_err_o = 1.
  - rst asserted asynchronously mid-cycle while PEND: pc_o = 3000 and pend_o = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and encodings for the MIPS front end: reset/exception
// addresses, word width, next-PC source codes and the redirect-buffer states.
package mips_pkg;

    localparam int          WORD_W         = 32;
    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
    localparam int unsigned IM_BYTES_DEF   = 4096;

    // NPC_HOLD marks a stalled edge on which the PC register is not loaded.
    typedef enum logic [2:0] {
        NPC_SEQ  = 3'd0,
        NPC_BR   = 3'd1,
        NPC_J    = 3'd2,
        NPC_JR   = 3'd3,
        NPC_EXC  = 3'd4,
        NPC_ERET = 3'd5,
        NPC_PEND = 3'd6,
        NPC_HOLD = 3'd7
    } npc_src_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } pend_state_t;

endpackage

// File: rtl/pc_fetch_if.sv
// Control/redirect inputs and PC outputs of the fetch PC stage.
// slave is the fetch stage itself, master is the pipeline driving it.
interface pc_fetch_if;
    logic        stall_i;
    logic        br_taken_i;
    logic [31:0] br_target_i;
    logic        j_i;
    logic [25:0] j_index_i;
    logic [31:0] id_pc_plus4_i;
    logic        jr_i;
    logic [31:0] jr_target_i;
    logic        exc_i;
    logic        eret_i;
    logic [31:0] epc_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        pend_o;
    logic        misalign_o;
    logic        range_err_o;
    logic [31:0] fetch_cnt_o;

    modport slave (
        input  stall_i, br_taken_i, br_target_i, j_i, j_index_i, id_pc_plus4_i,
               jr_i, jr_target_i, exc_i, eret_i, epc_i,
        output pc_o, pc_plus4_o, pend_o, misalign_o, range_err_o, fetch_cnt_o
    );

    modport master (
        output stall_i, br_taken_i, br_target_i, j_i, j_index_i, id_pc_plus4_i,
               jr_i, jr_target_i, exc_i, eret_i, epc_i,
        input  pc_o, pc_plus4_o, pend_o, misalign_o, range_err_o, fetch_cnt_o
    );
endinterface

// File: rtl/npc_sel.sv
// Combinational next-PC selection: decodes the ID-stage redirect and picks
// the next PC and its source by priority exc > eret > stall > redirect > pending > seq.
module npc_sel
    import mips_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic        i_exc,
    input  logic        i_eret,
    input  logic        i_stall,
    input  logic        i_br_taken,
    input  logic [31:0] i_br_target,
    input  logic        i_j,
    input  logic [25:0] i_j_index,
    input  logic [31:0] i_id_pc_plus4,
    input  logic        i_jr,
    input  logic [31:0] i_jr_target,
    input  logic [31:0] i_epc,
    input  logic        i_pend_valid,
    input  logic [31:0] i_pend_target,
    input  logic [31:0] i_pc,
    output logic        o_redir,
    output logic [31:0] o_redir_tgt,
    output logic [31:0] o_npc,
    output npc_src_t    o_src
);

    npc_src_t w_redir_src;
    logic     w_unused_pc4;

    // Only the region bits of PC+4 feed the jump target.
    assign w_unused_pc4 = &{1'b0, i_id_pc_plus4[27:0]};

    always_comb begin
        o_redir     = i_jr | i_j | i_br_taken;
        o_redir_tgt = i_br_target;
        w_redir_src = NPC_BR;
        if (i_jr) begin
            o_redir_tgt = i_jr_target;
            w_redir_src = NPC_JR;
        end else if (i_j) begin
            o_redir_tgt = {i_id_pc_plus4[31:28], i_j_index, 2'b00};
            w_redir_src = NPC_J;
        end
    end

    always_comb begin
        o_npc = i_pc + 32'd4;
        o_src = NPC_SEQ;
        if (i_exc) begin
            o_npc = EXC_VECTOR;
            o_src = NPC_EXC;
        end else if (i_eret) begin
            o_npc = i_epc;
            o_src = NPC_ERET;
        end else if (i_stall) begin
            o_npc = i_pc;
            o_src = NPC_HOLD;
        end else if (o_redir) begin
            o_npc = o_redir_tgt;
            o_src = w_redir_src;
        end else if (i_pend_valid) begin
            o_npc = i_pend_target;
            o_src = NPC_PEND;
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// Fetch PC register with redirect buffering across stalls, fetch counter and
// alignment/window flags for the 4 KiB instruction memory.
//   state   | meaning
//   ST_IDLE | no redirect buffered
//   ST_PEND | redirect captured during a stall, applied on the first unstalled edge
module pc_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter int unsigned IM_BYTES   = IM_BYTES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    pc_fetch_if.slave   bus
);

    logic [31:0] r_pc;
    logic [31:0] r_pend_target;
    logic [31:0] r_fetch_cnt;
    pend_state_t r_state;

    logic        w_pend_valid;
    logic        w_redir;
    logic [31:0] w_redir_tgt;
    logic [31:0] w_npc;
    npc_src_t    w_src;
    logic        w_load;
    logic [31:0] w_pc_off;

    assign w_pend_valid = (r_state == ST_PEND);
    assign w_load       = (w_src != NPC_HOLD);

    npc_sel #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_npc_sel (
        .i_exc         (bus.exc_i),
        .i_eret        (bus.eret_i),
        .i_stall       (bus.stall_i),
        .i_br_taken    (bus.br_taken_i),
        .i_br_target   (bus.br_target_i),
        .i_j           (bus.j_i),
        .i_j_index     (bus.j_index_i),
        .i_id_pc_plus4 (bus.id_pc_plus4_i),
        .i_jr          (bus.jr_i),
        .i_jr_target   (bus.jr_target_i),
        .i_epc         (bus.epc_i),
        .i_pend_valid  (w_pend_valid),
        .i_pend_target (r_pend_target),
        .i_pc          (r_pc),
        .o_redir       (w_redir),
        .o_redir_tgt   (w_redir_tgt),
        .o_npc         (w_npc),
        .o_src         (w_src)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_pend_target <= RESET_PC;
            r_fetch_cnt   <= 32'd0;
            r_state       <= ST_IDLE;
        end else begin
            if (w_load) begin
                r_pc        <= w_npc;
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
                r_state     <= ST_IDLE;
            end else if (w_redir) begin
                // Newest redirect seen during the stall replaces any older one.
                r_pend_target <= w_redir_tgt;
                r_state       <= ST_PEND;
            end
        end
    end

    // Unsigned offset from the window base: PCs below the base wrap and flag.
    assign w_pc_off        = r_pc - RESET_PC;
    assign bus.pc_o        = r_pc;
    assign bus.pc_plus4_o  = r_pc + 32'd4;
    assign bus.pend_o      = w_pend_valid;
    assign bus.misalign_o  = (r_pc[1:0] != 2'b00);
    assign bus.range_err_o = (w_pc_off >= 32'(IM_BYTES));
    assign bus.fetch_cnt_o = r_fetch_cnt;

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: stimulus pushes hand-computed expected state,
// a negedge monitor pops and compares against the DUT.
module tb_pc_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pc_fetch_if u_if ();

    pc_fetch u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        pend;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] off;
            e   = q.pop_front();
            off = e.pc - 32'h0000_3000;
            check({e.name, ".pc"},       u_if.pc_o,                e.pc);
            check({e.name, ".pc_plus4"}, u_if.pc_plus4_o,          e.pc + 32'd4);
            check({e.name, ".pend"},     32'(u_if.pend_o),         32'(e.pend));
            check({e.name, ".cnt"},      u_if.fetch_cnt_o,         e.cnt);
            check({e.name, ".misalign"}, 32'(u_if.misalign_o),     32'(e.pc[1:0] != 2'b00));
            check({e.name, ".range"},    32'(u_if.range_err_o),    32'(off >= 32'd4096));
        end
    end

    task automatic expect_now(input string name, input logic [31:0] pc, input logic pend,
                              input logic [31:0] cnt);
        exp_t e;
        e.name = name;
        e.pc   = pc;
        e.pend = pend;
        e.cnt  = cnt;
        q.push_back(e);
    endtask

    task automatic step(input string name, input logic [31:0] pc, input logic pend,
                        input logic [31:0] cnt);
        @(posedge clk);
        #1;
        expect_now(name, pc, pend, cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        u_if.stall_i       = 1'b0;
        u_if.br_taken_i    = 1'b0;
        u_if.br_target_i   = 32'd0;
        u_if.j_i           = 1'b0;
        u_if.j_index_i     = 26'd0;
        u_if.id_pc_plus4_i = 32'd0;
        u_if.jr_i          = 1'b0;
        u_if.jr_target_i   = 32'd0;
        u_if.exc_i         = 1'b0;
        u_if.eret_i        = 1'b0;
        u_if.epc_i         = 32'd0;

        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        expect_now("reset", 32'h3000, 1'b0, 32'd0);
        step("seq1", 32'h3004, 1'b0, 32'd1);
        step("seq2", 32'h3008, 1'b0, 32'd2);
        step("seq3", 32'h300C, 1'b0, 32'd3);
        step("seq4", 32'h3010, 1'b0, 32'd4);

        u_if.br_taken_i = 1'b1; u_if.br_target_i = 32'h3040;
        step("branch", 32'h3040, 1'b0, 32'd5);
        u_if.br_taken_i = 1'b0;
        step("after_br", 32'h3044, 1'b0, 32'd6);

        u_if.stall_i = 1'b1; u_if.j_i = 1'b1;
        u_if.j_index_i = 26'h000C10; u_if.id_pc_plus4_i = 32'h3008;
        step("stall_j1", 32'h3044, 1'b1, 32'd6);
        u_if.j_i = 1'b0;
        step("stall_j2", 32'h3044, 1'b1, 32'd6);
        step("stall_j3", 32'h3044, 1'b1, 32'd6);
        u_if.stall_i = 1'b0;
        step("pend_apply", 32'h3040, 1'b0, 32'd7);
        step("after_pend", 32'h3044, 1'b0, 32'd8);

        u_if.stall_i = 1'b1; u_if.jr_i = 1'b1; u_if.jr_target_i = 32'h3100;
        step("stall_jr", 32'h3044, 1'b1, 32'd8);
        u_if.jr_i = 1'b0; u_if.exc_i = 1'b1;
        step("exc_in_stall", 32'h4180, 1'b0, 32'd9);
        u_if.exc_i = 1'b0; u_if.stall_i = 1'b0;
        step("no_stale_jr", 32'h4184, 1'b0, 32'd10);

        u_if.exc_i = 1'b1; u_if.eret_i = 1'b1; u_if.epc_i = 32'h3020;
        step("exc_over_eret", 32'h4180, 1'b0, 32'd11);
        u_if.exc_i = 1'b0;
        step("eret", 32'h3020, 1'b0, 32'd12);
        u_if.eret_i = 1'b0;
        step("after_eret", 32'h3024, 1'b0, 32'd13);

        u_if.jr_i = 1'b1; u_if.jr_target_i = 32'h3002;
        step("misalign", 32'h3002, 1'b0, 32'd14);
        u_if.jr_target_i = 32'h4000;
        step("range_top", 32'h4000, 1'b0, 32'd15);
        u_if.jr_target_i = 32'h3FFC;
        step("range_last", 32'h3FFC, 1'b0, 32'd16);
        u_if.jr_target_i = 32'h2FFC;
        step("below_base", 32'h2FFC, 1'b0, 32'd17);
        u_if.jr_target_i = 32'hFFFF_FFFC;
        step("pc_max", 32'hFFFF_FFFC, 1'b0, 32'd18);
        u_if.jr_i = 1'b0;
        step("pc_wrap", 32'h0000_0000, 1'b0, 32'd19);

        u_if.stall_i = 1'b1; u_if.br_taken_i = 1'b1; u_if.br_target_i = 32'h3200;
        step("stall_br", 32'h0, 1'b1, 32'd19);
        u_if.br_taken_i = 1'b0; u_if.stall_i = 1'b0;
        u_if.jr_i = 1'b1; u_if.jr_target_i = 32'h3300;
        step("live_wins", 32'h3300, 1'b0, 32'd20);
        u_if.jr_i = 1'b0;
        step("after_live", 32'h3304, 1'b0, 32'd21);

        u_if.stall_i = 1'b1; u_if.br_taken_i = 1'b1; u_if.br_target_i = 32'h3400;
        step("ovw1", 32'h3304, 1'b1, 32'd21);
        u_if.br_target_i = 32'h3500;
        step("ovw2", 32'h3304, 1'b1, 32'd21);
        u_if.br_taken_i = 1'b0; u_if.stall_i = 1'b0;
        step("ovw_apply", 32'h3500, 1'b0, 32'd22);

        u_if.stall_i = 1'b1; u_if.br_taken_i = 1'b1; u_if.br_target_i = 32'h3600;
        step("pend_pre_rst", 32'h3500, 1'b1, 32'd22);
        u_if.br_taken_i = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 expect_now("async_rst", 32'h3000, 1'b0, 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        u_if.stall_i = 1'b0;
        step("post_rst", 32'h3004, 1'b0, 32'd1);

        @(negedge clk);
        #1;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
